// File: rtl/reg_dump_reader_pkg.sv
// Shared defaults, FSM encodings and the beat payload type for the register dump reader.
package reg_dump_reader_pkg;

    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] idx;
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready stream carrying one (index, data) register beat per handshake.
interface reg_dump_reader_if #(
    parameter int unsigned ADDR_W = reg_dump_reader_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = reg_dump_reader_pkg::DEF_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid, out_idx, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_idx, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a range of register-file addresses over one combinational read port and
// streams each (index, data) pair out through a single-entry output register.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    reg_dump_reader_if.master out_if,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              valid_q,     valid_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              last_q,      last_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              handshake;
    logic              can_load;

    // Next state, fetch pointer and output-register load.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        data_d      = data_q;
        last_d      = last_q;
        handshake   = valid_q && out_if.out_ready;
        can_load    = (!valid_q || handshake) && (remaining_q != '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        rd_addr_d   = start_addr;
                        remaining_d = (count > MAX_CNT) ? MAX_CNT : count;
                        state_d     = RUN;
                    end else begin
                        state_d     = FINISH;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = FINISH;
                end else if (handshake && last_q) begin
                    valid_d = 1'b0;
                    state_d = FINISH;
                end else if (can_load) begin
                    valid_d     = 1'b1;
                    data_d      = rd_data;
                    idx_d       = rd_addr_q;
                    last_d      = (remaining_q == CNT_W'(1));
                    rd_addr_d   = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                end else if (handshake) begin
                    valid_d = 1'b0;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr          = rd_addr_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_idx   = idx_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: register-file model as responder, beat scoreboard.
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    localparam int unsigned AW = DEF_ADDR_W;
    localparam int unsigned DW = DEF_DATA_W;
    localparam int unsigned NR = DEF_NUM_REGS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   count = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] regs [NR];

    reg_dump_reader_if dif ();

    reg_dump_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_if     (dif.master),
        .busy       (busy),
        .done       (done)
    );

    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    beat_t sb [$];
    int    checks = 0;
    int    errors = 0;
    int    beats  = 0;
    int    dones  = 0;
    logic  stall_q = 1'b0;
    beat_t held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops on handshakes, stability under stall, done pulse count.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            beat_t exp_b;
            if (done) dones++;
            if (stall_q) begin
                check("stall_valid", 32'(dif.out_valid), 32'd1);
                check("stall_idx",   32'(dif.out_idx),   32'(held.idx));
                check("stall_data",  dif.out_data,       held.data);
                check("stall_last",  32'(dif.out_last),  32'(held.last));
            end
            if (dif.out_valid && dif.out_ready) begin
                beats++;
                check("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("beat_idx",  32'(dif.out_idx),  32'(exp_b.idx));
                    check("beat_data", dif.out_data,      exp_b.data);
                    check("beat_last", 32'(dif.out_last), 32'(exp_b.last));
                end
            end
            stall_q   = dif.out_valid && !dif.out_ready && !abort;
            held.idx  = dif.out_idx;
            held.data = dif.out_data;
            held.last = dif.out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input int sa, input int cnt);
        int    n;
        beat_t b;
        n = (cnt > int'(NR)) ? int'(NR) : cnt;
        for (int i = 0; i < n; i++) begin
            b.idx  = AW'((sa + i) % int'(NR));
            b.data = regs[b.idx];
            b.last = (i == n - 1);
            sb.push_back(b);
        end
        start_addr = AW'(sa);
        count      = (AW+1)'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // mode 0: sink always ready; mode 1: ready pattern 1,0,0 repeating.
    task automatic run_to_done(input int mode, input int budget, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            dif.out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            tick();
            cyc++;
            seen = done;
        end
        check("done_seen", 32'(seen), 32'd1);
        dif.out_ready = 1'b1;
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after",     32'(busy), 32'd0);
        check("sb_drained",     32'(sb.size()), 32'd0);
        check("done_count",     32'(dones), 32'd1);
    endtask

    initial begin
        int cyc;
        int guard;
        for (int i = 0; i < int'(NR); i++) regs[i] = 32'hA000_0000 + 32'(i);
        dif.out_ready = 1'b1;

        #12;
        check("rst_valid",   32'(dif.out_valid), 32'd0);
        check("rst_idx",     32'(dif.out_idx),   32'd0);
        check("rst_data",    dif.out_data,       32'd0);
        check("rst_last",    32'(dif.out_last),  32'd0);
        check("rst_rd_addr", 32'(rd_addr),       32'd0);
        check("rst_busy",    32'(busy),          32'd0);
        check("rst_done",    32'(done),          32'd0);
        rst_n = 1'b1;
        tick();

        // Full dump: first beat one edge after RUN entry, then one beat per cycle.
        dones = 0;
        start_dump(0, 32);
        check("lat_valid_e0", 32'(dif.out_valid), 32'd0);
        check("lat_busy_e0",  32'(busy),          32'd1);
        run_to_done(0, 60, cyc);
        check("full_cycles", 32'(cyc), 32'd33);

        // Address wrap.
        dones = 0;
        start_dump(30, 4);
        run_to_done(0, 20, cyc);
        check("wrap_cycles", 32'(cyc), 32'd5);

        // Back-pressure.
        dones = 0;
        start_dump(9, 5);
        run_to_done(1, 40, cyc);

        // Empty dump.
        dones = 0;
        start_dump(4, 0);
        check("empty_done",  32'(done),          32'd1);
        check("empty_busy",  32'(busy),          32'd0);
        check("empty_valid", 32'(dif.out_valid), 32'd0);
        tick();
        check("empty_done_off", 32'(done),  32'd0);
        check("empty_dones",    32'(dones), 32'd1);
        check("empty_beats",    32'(sb.size()), 32'd0);

        // Count above NUM_REGS clamps to a full pass.
        dones = 0;
        start_dump(5, 40);
        run_to_done(0, 60, cyc);
        check("clamp_cycles", 32'(cyc), 32'd33);

        // Abort after three beats, with an ignored mid-dump start.
        dones = 0;
        beats = 0;
        start_dump(2, 10);
        guard = 0;
        while (beats < 1 && guard < 20) begin tick(); guard++; end
        start_addr = AW'(20);
        count      = (AW+1)'(2);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("ignored_start_busy", 32'(busy), 32'd1);
        guard = 0;
        while (beats < 3 && guard < 20) begin tick(); guard++; end
        check("abort_beats", 32'(beats), 32'd3);
        dif.out_ready = 1'b0;
        abort         = 1'b1;
        tick();
        abort         = 1'b0;
        check("abort_valid", 32'(dif.out_valid), 32'd0);
        check("abort_done",  32'(done),          32'd1);
        check("abort_left",  32'(sb.size()),     32'd7);
        sb.delete();
        tick();
        dif.out_ready = 1'b1;
        check("abort_done_off", 32'(done),  32'd0);
        check("abort_busy",     32'(busy),  32'd0);
        check("abort_dones",    32'(dones), 32'd1);

        dones = 0;
        start_dump(7, 3);
        run_to_done(0, 20, cyc);
        check("post_abort_cycles", 32'(cyc), 32'd4);

        // Asynchronous reset mid-dump.
        dones = 0;
        start_dump(0, 20);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",   32'(dif.out_valid), 32'd0);
        check("arst_idx",     32'(dif.out_idx),   32'd0);
        check("arst_data",    dif.out_data,       32'd0);
        check("arst_last",    32'(dif.out_last),  32'd0);
        check("arst_rd_addr", 32'(rd_addr),       32'd0);
        check("arst_busy",    32'(busy),          32'd0);
        check("arst_done",    32'(done),          32'd0);
        sb.delete();
        repeat (2) tick();
        #3;
        rst_n = 1'b1;
        repeat (2) tick();
        check("arst_no_done", 32'(dones),         32'd0);
        check("arst_idle",    32'(dif.out_valid), 32'd0);

        start_dump(3, 6);
        run_to_done(0, 20, cyc);
        check("post_rst_cycles", 32'(cyc), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
